param_stream_loader: RTL
========================

// Module: param_stream_loader
// PURPOSE
//  Multi-channel loader; replaces file-based init. Host streams 16-bit words per channel (CNN weights, FC weights, image).
//  Block writes them into the shared accelerator parameter RAM at a per-channel base, with valid/ready backpressure.
//  Raises a sticky per-channel done flag. Sits between the host stream port and the parameter RAM write port.
// PARAMETERS
//  DATA_W   16                      word width
//  ADDR_W   17                      RAM address width
//  LEN_W    17                      transfer length width (words)
//  NUM_CH   3                       channels (0=CNN, 1=FC, 2=IMG)
//  CH_BASE  {17'd61922,17'd50704,17'd0}  packed NUM_CH*ADDR_W bases; ch i at [i*ADDR_W +: ADDR_W]
// PORTS
//  clk        in  1        clock, all logic on posedge
//  rst        in  1        synchronous reset, active-high
//  start      in  1        pulse: begin a load
//  start_ch   in  clog2(NUM_CH)  channel for start
//  start_len  in  LEN_W    words to load
//  s_valid    in  1        stream word valid
//  s_data     in  DATA_W   stream word
//  s_ready    out 1        stream accept
//  mem_we     out 1        RAM write strobe
//  mem_addr   out ADDR_W   RAM write address
//  mem_wdata  out DATA_W   RAM write data
//  mem_ready  in  1        RAM accepts write when mem_we&&mem_ready
//  busy       out 1        load in progress
//  ch_done    out NUM_CH   sticky done per channel
//  cksum_err  out 1        checksum mismatch (macro only; tied 0 otherwise)
// BEHAVIOUR
//  Reset: busy=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, ch_done=0, cksum_err=0, FSM=IDLE.
//  FSM IDLE->LOAD on start (latch ch, len, addr=CH_BASE[ch]; clear ch_done[ch]); LOAD->DRAIN when last word accepted;
//   DRAIN->DONE when the output register empties; DONE->IDLE in 1 cycle, setting ch_done[ch].
//  start_len=0: IDLE->DONE directly, no writes; ch_done set 2 cycles after start.
//  start while busy: ignored, no state change. start_ch>=NUM_CH: ignored.
//  s_ready = (LOAD) && words_left!=0 && (!mem_we || mem_ready); a word transfers on s_valid&&s_ready.
//  Accepted word at cycle N -> mem_we/mem_addr/mem_wdata valid from N+1; held stable until mem_ready.
//  Full throughput 1 word/cycle when mem_ready=1; mem_ready=0 stalls with no loss or duplication.
//  Address increments by 1 per accepted word, wraps modulo 2^ADDR_W. No region-overrun check.
//  ch_done[i] stays set until rst or a new start on channel i.
//  rst mid-load aborts: no further writes, all flags cleared; partial RAM contents undefined.
// CONFIGURATION
//  LOADER_CKSUM_EN defined: after len data words, one extra word (the expected 16-bit wrap-around sum) is accepted.
//   It is not written. cksum_err is set at DONE if the sum mismatches and is cleared on next start/rst; ch_done is set regardless.
//  LOADER_CKSUM_EN undefined: exactly len words accepted; cksum_err tied 0.
// STRUCTURE
//  Package loader_pkg: FSM state localparams (IDLE, LOAD, DRAIN, DONE), channel indices CH_CNN/CH_FC/CH_IMG, default bases.
//  Sub-module loader_wr_stage: one-entry output register (data+addr) with valid/ready.
//   It drives mem_* and supplies the !mem_we||mem_ready term.
// TESTING
//  1 start ch0 len=5, s_valid=1 data 1..5, mem_ready=1 -> writes addr 0..4 on cycles 2..6; ch_done[0] set after last.
//  2 start ch1 len=4, mem_ready toggles 1,0,0,1... -> writes 50704..50707 in order, each data held while stalled, no duplicates.
//  3 start ch2 len=0 -> no mem_we; ch_done[2]=1 two cycles after start; busy high for those cycles only.
//  4 start ch0 during ch1 load -> ignored; ch1 completes normally; ch_done=3'b010.
//  5 rst asserted after 3 of 8 words -> next cycle mem_we=0, busy=0, ch_done=0; new start loads normally.
//  6 LOADER_CKSUM_EN: len=3 data 0x0001,0x0002,0xFFFF, sum word 0x0002 -> cksum_err=0; sum word 0x0003 -> cksum_err=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the parameter stream loader: FSM states, channel ids, default bases.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CH_CNN = 0;
  localparam int CH_FC  = 1;
  localparam int CH_IMG = 2;

  // Channel i base lives at [i*17 +: 17]; CNN region starts at 0.
  localparam logic [3*17-1:0] DEFAULT_CH_BASE = {17'd61922, 17'd50704, 17'd0};

endpackage

// File: rtl/loader_wr_stage.sv
// One-entry output register driving the RAM write port; a new word loads when empty or when the
// held write is being accepted, so a stalled write keeps address and data stable.
module loader_wr_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready
);

  assign in_ready = !mem_we || mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (in_ready) begin
      mem_we <= in_valid;
      if (in_valid) begin
        mem_addr  <= in_addr;
        mem_wdata <= in_data;
      end
    end
  end

endmodule

// File: rtl/param_stream_loader.sv
// Streams host words into the parameter RAM at a per-channel base with valid/ready backpressure.
// Optional LOADER_CKSUM_EN: a trailing 16-bit sum word is accepted, checked and not written.
module param_stream_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 17,
  parameter int NUM_CH = 3,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = DEFAULT_CH_BASE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NUM_CH)-1:0] start_ch,
  input  logic [LEN_W-1:0]          start_len,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [NUM_CH-1:0]         ch_done,
  output logic                      cksum_err
);

  localparam int CH_W = $clog2(NUM_CH);

  state_t            state, state_nx;
  logic [CH_W-1:0]   ch_q;
  logic [LEN_W-1:0]  words_left;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_tbl [NUM_CH];
  logic              wr_rdy, start_ok, accept, data_word, last_word, more;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_base
    assign base_tbl[i] = CH_BASE[i*ADDR_W +: ADDR_W];
  end

  assign start_ok  = start && (state == IDLE) && (int'(start_ch) < NUM_CH);
  assign s_ready   = (state == LOAD) && more && wr_rdy;
  assign accept    = s_valid && s_ready;
  assign data_word = accept && (words_left != '0);
  assign busy      = (state != IDLE);

`ifdef LOADER_CKSUM_EN
  logic              sum_seen, cks_bad;
  logic [DATA_W-1:0] sum_q;

  // Once the data words are exhausted the next accepted word is the checksum.
  assign more      = (words_left != '0) || !sum_seen;
  assign last_word = (words_left == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_seen  <= 1'b0;
      sum_q     <= '0;
      cks_bad   <= 1'b0;
      cksum_err <= 1'b0;
    end else begin
      if (start_ok) begin
        sum_seen  <= 1'b0;
        sum_q     <= '0;
        cks_bad   <= 1'b0;
        cksum_err <= 1'b0;
      end else if (data_word) begin
        sum_q <= sum_q + s_data;
      end else if (accept) begin
        sum_seen <= 1'b1;
        cks_bad  <= (s_data != sum_q);
      end
      if (state == DONE) cksum_err <= cks_bad;
    end
  end
`else
  assign more      = (words_left != '0);
  assign last_word = (words_left == LEN_W'(1));
  assign cksum_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = (start_len == '0) ? DONE : LOAD;
      LOAD:    if (accept && last_word) state_nx = DRAIN;
      DRAIN:   if (!mem_we) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch_q       <= '0;
      words_left <= '0;
      addr_q     <= '0;
      ch_done    <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        ch_q              <= start_ch;
        words_left        <= start_len;
        addr_q            <= base_tbl[start_ch];
        ch_done[start_ch] <= 1'b0;
      end else if (data_word) begin
        words_left <= words_left - LEN_W'(1);
        addr_q     <= addr_q + ADDR_W'(1);
      end
      if (state == DONE) ch_done[ch_q] <= 1'b1;
    end
  end

  loader_wr_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .in_valid (data_word),
    .in_addr  (addr_q),
    .in_data  (s_data),
    .in_ready (wr_rdy),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

endmodule
